// File: rtl/gupsample.sv
// gupsample -- inverse of global average pooling.
//
// Each accepted input sample is replayed as exactly POOL_SIZE output beats.
// Every beat carries the held sample and its position within the pool.
//
// Handshake rule for both ports: a transfer happens on a rising clock edge
// when valid and ready are both high. The producer holds valid and data
// stable until that transfer.
//
// Ports:
//   clk                  rising-edge clock
//   rst                  synchronous active-high reset
//   gupsample_ready_in   block can take a sample this cycle
//   gupsample_valid_in   upstream presents a sample
//   gupsample_data_in    sample to broadcast
//   gupsample_ready_out  downstream accepts the current beat
//   gupsample_valid_out  output beat present
//   gupsample_data_out   held sample value
//   gupsample_index_out  beat position within the pool, 0..POOL_SIZE-1
//   gupsample_last_out   current beat is the final one of the pool
//   dbg_bcast_o          FSM state for observation (1 = BCAST, 0 = IDLE)
module gupsample #(
  parameter int DATA_WIDTH = 12,
  parameter int POOL_SIZE  = 250,
  // Same result as the clog2 helper in cnn1d_pkg, clamped to at least 1 bit.
  localparam int COUNTER_WIDTH = (POOL_SIZE > 1) ? $clog2(POOL_SIZE) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     gupsample_ready_in,
  input  logic                     gupsample_valid_in,
  input  logic [DATA_WIDTH-1:0]    gupsample_data_in,
  input  logic                     gupsample_ready_out,
  output logic                     gupsample_valid_out,
  output logic [DATA_WIDTH-1:0]    gupsample_data_out,
  output logic [COUNTER_WIDTH-1:0] gupsample_index_out,
  output logic                     gupsample_last_out,
  output logic                     dbg_bcast_o
);

  typedef enum logic {
    IDLE  = 1'b0,
    BCAST = 1'b1
  } state_t;

  localparam logic [COUNTER_WIDTH-1:0] LAST_IDX = COUNTER_WIDTH'(POOL_SIZE - 1);
  localparam logic                     SINGLE   = (POOL_SIZE == 1);

  state_t                   state_q;
  logic [DATA_WIDTH-1:0]    data_q;
  logic [COUNTER_WIDTH-1:0] idx_q;
  logic [COUNTER_WIDTH-1:0] idx_d;
  logic                     last_q;
  logic                     in_hs;
  logic                     out_hs;

  // In BCAST a new sample can only enter while the final beat is leaving,
  // which is what lets consecutive pools run with no bubble.
  assign gupsample_ready_in = (state_q == IDLE) | (last_q & gupsample_ready_out);

  assign in_hs  = gupsample_ready_in & gupsample_valid_in;
  assign out_hs = (state_q == BCAST) & gupsample_ready_out;
  assign idx_d  = idx_q + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      idx_q   <= '0;
      last_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_hs) begin
            data_q  <= gupsample_data_in;
            idx_q   <= '0;
            last_q  <= SINGLE;
            state_q <= BCAST;
          end
        end
        BCAST: begin
          if (out_hs) begin
            if (last_q) begin
              if (in_hs) begin
                // Final beat leaves while the next sample arrives.
                data_q  <= gupsample_data_in;
                idx_q   <= '0;
                last_q  <= SINGLE;
              end else begin
                idx_q   <= '0;
                last_q  <= 1'b0;
                state_q <= IDLE;
              end
            end else begin
              // last_q guards this path, so idx_q never passes LAST_IDX.
              idx_q  <= idx_d;
              last_q <= (idx_d == LAST_IDX);
            end
          end
        end
        default: begin
          state_q <= IDLE;
          idx_q   <= '0;
          last_q  <= 1'b0;
        end
      endcase
    end
  end

  assign gupsample_valid_out = (state_q == BCAST);
  assign gupsample_data_out  = data_q;
  assign gupsample_index_out = idx_q;
  assign gupsample_last_out  = last_q;
  assign dbg_bcast_o         = (state_q == BCAST);

endmodule

// File: tb/tb_gupsample.sv
// Bench for gupsample: a POOL_SIZE=4 instance for the main scenarios and a
// POOL_SIZE=1 instance for the single-beat case.
module tb_gupsample;

  localparam int DW = 12;
  localparam int PS = 4;
  localparam int W  = DW + 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic          ready_in, valid_in, ready_out, valid_out, last_out, dbg;
  logic [DW-1:0] data_in, data_out;
  logic [1:0]    idx_out;

  logic          ready_in1, valid_in1, ready_out1, valid_out1, last_out1, dbg1;
  logic [DW-1:0] data_in1, data_out1;
  logic [0:0]    idx_out1;

  logic [W-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;
  int n_in  = 0;
  int n_out = 0;

  always #5 clk = ~clk;

  gupsample #(.DATA_WIDTH(DW), .POOL_SIZE(PS)) dut (
    .clk(clk), .rst(rst),
    .gupsample_ready_in(ready_in), .gupsample_valid_in(valid_in),
    .gupsample_data_in(data_in), .gupsample_ready_out(ready_out),
    .gupsample_valid_out(valid_out), .gupsample_data_out(data_out),
    .gupsample_index_out(idx_out), .gupsample_last_out(last_out),
    .dbg_bcast_o(dbg)
  );

  gupsample #(.DATA_WIDTH(DW), .POOL_SIZE(1)) dut1 (
    .clk(clk), .rst(rst),
    .gupsample_ready_in(ready_in1), .gupsample_valid_in(valid_in1),
    .gupsample_data_in(data_in1), .gupsample_ready_out(ready_out1),
    .gupsample_valid_out(valid_out1), .gupsample_data_out(data_out1),
    .gupsample_index_out(idx_out1), .gupsample_last_out(last_out1),
    .dbg_bcast_o(dbg1)
  );

  // Scoreboard producer: an accepted sample yields PS expected beats.
  always @(negedge clk) begin
    if (!rst && ready_in && valid_in) begin
      n_in++;
      for (int i = 0; i < PS; i++) exp_q.push_back({data_in, 2'(i)});
    end
  end

  // Scoreboard consumer: each output handshake is checked against the queue.
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (!rst && valid_out && ready_out) begin
      n_out++;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL sb_underflow: beat data=%h idx=%0d with nothing expected", data_out, idx_out);
      end else begin
        e = exp_q.pop_front();
        if ({data_out, idx_out} !== e || last_out !== (e[1:0] == 2'd3)) begin
          bad++;
          $display("FAIL sb_beat: got data=%h idx=%0d last=%b, want data=%h idx=%0d last=%b",
                   data_out, idx_out, last_out, e[W-1:2], e[1:0], (e[1:0] == 2'd3));
        end
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1; valid_in = 0; data_in = '0; ready_out = 0;
    valid_in1 = 0; data_in1 = '0; ready_out1 = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", valid_out); end
    total++; if (last_out !== 1'b0) begin bad++; $display("FAIL rst_last: got %b want 0", last_out); end
    total++; if (idx_out !== 2'd0) begin bad++; $display("FAIL rst_index: got %0d want 0", idx_out); end
    total++; if (data_out !== 12'h000) begin bad++; $display("FAIL rst_data: got %h want 000", data_out); end
    total++; if (ready_in !== 1'b1) begin bad++; $display("FAIL rst_ready_in: got %b want 1", ready_in); end
    total++; if (valid_out1 !== 1'b0 || ready_in1 !== 1'b1) begin
      bad++; $display("FAIL rst_pool1: got valid=%b ready_in=%b want 0/1", valid_out1, ready_in1);
    end
  endtask

  task automatic test_single();
    @(posedge clk); #1 valid_in = 1; data_in = 12'h123; ready_out = 1;
    @(negedge clk);
    total++; if (ready_in !== 1'b1) begin bad++; $display("FAIL single_ready_in: got %b want 1", ready_in); end
    total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL single_latency: got valid %b want 0", valid_out); end
    @(posedge clk); #1 valid_in = 0; data_in = 12'h7E7;
    for (int b = 0; b < PS; b++) begin
      @(negedge clk);
      total++;
      if (valid_out !== 1'b1 || data_out !== 12'h123 || idx_out !== 2'(b) || last_out !== (b == 3)) begin
        bad++;
        $display("FAIL single_beat%0d: got v=%b d=%h i=%0d l=%b want v=1 d=123 i=%0d l=%b",
                 b, valid_out, data_out, idx_out, last_out, b, (b == 3));
      end
    end
    @(negedge clk);
    total++; if (valid_out !== 1'b0 || dbg !== 1'b0) begin
      bad++; $display("FAIL single_idle: got valid=%b state=%b want 0/0", valid_out, dbg);
    end
    total++; if (data_out !== 12'h123) begin bad++; $display("FAIL single_hold_idle: got %h want 123", data_out); end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] want;
    @(posedge clk); #1 valid_in = 1; data_in = 12'h0AA; ready_out = 1;
    @(posedge clk); #1 data_in = 12'h055;
    for (int b = 0; b < 2 * PS; b++) begin
      @(negedge clk);
      want = (b < PS) ? 12'h0AA : 12'h055;
      total++;
      if (valid_out !== 1'b1 || data_out !== want || idx_out !== 2'(b % PS)) begin
        bad++;
        $display("FAIL b2b_beat%0d: got v=%b d=%h i=%0d want v=1 d=%h i=%0d",
                 b, valid_out, data_out, idx_out, want, b % PS);
      end
      total++;
      if (ready_in !== (b % PS == PS - 1)) begin
        bad++; $display("FAIL b2b_ready_in%0d: got %b want %b", b, ready_in, (b % PS == PS - 1));
      end
      if (b == PS - 1) begin
        @(posedge clk); #1 valid_in = 0;
      end
    end
    @(negedge clk);
    total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL b2b_idle: got %b want 0", valid_out); end
  endtask

  task automatic test_backpressure();
    logic [3:0]    pat = 4'b1001;
    int            hs = 0;
    int            c  = 0;
    logic          stalled = 0;
    logic [1:0]    p_idx;
    logic          p_last;
    logic [DW-1:0] p_data;
    @(posedge clk); #1 valid_in = 1; data_in = 12'hFFF; ready_out = 0;
    @(posedge clk); #1 valid_in = 0; data_in = 12'h000;
    while (hs < PS && c < 40) begin
      ready_out = pat[3 - (c % 4)];
      @(negedge clk);
      if (stalled) begin
        total++;
        if (idx_out !== p_idx || last_out !== p_last || data_out !== p_data || valid_out !== 1'b1) begin
          bad++; $display("FAIL bp_hold: got i=%0d l=%b d=%h v=%b want i=%0d l=%b d=%h v=1",
                          idx_out, last_out, data_out, valid_out, p_idx, p_last, p_data);
        end
      end
      total++;
      if (valid_out !== 1'b1 || data_out !== 12'hFFF || idx_out !== 2'(hs)) begin
        bad++; $display("FAIL bp_beat: got v=%b d=%h i=%0d want v=1 d=fff i=%0d", valid_out, data_out, idx_out, hs);
      end
      total++;
      if (ready_in !== (ready_out && hs == PS - 1)) begin
        bad++; $display("FAIL bp_ready_in: got %b want %b", ready_in, (ready_out && hs == PS - 1));
      end
      p_idx = idx_out; p_last = last_out; p_data = data_out;
      stalled = !ready_out;
      if (ready_out) hs++;
      c++;
      @(posedge clk); #1;
    end
    total++; if (hs != PS) begin bad++; $display("FAIL bp_timeout: got %0d handshakes want %0d", hs, PS); end
    ready_out = 1;
    @(negedge clk);
    total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL bp_idle: got %b want 0", valid_out); end
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1 valid_in = 1; data_in = 12'h300; ready_out = 1;
    @(posedge clk); #1 valid_in = 0;
    @(posedge clk);
    @(posedge clk); #1 rst = 1; valid_in = 1; data_in = 12'h5A5;
    @(posedge clk); #1 rst = 0; valid_in = 0; exp_q.delete();
    @(negedge clk);
    total++;
    if (valid_out !== 1'b0 || idx_out !== 2'd0 || data_out !== 12'h000 || ready_in !== 1'b1) begin
      bad++; $display("FAIL rstmid_state: got v=%b i=%0d d=%h rdy=%b want 0/0/000/1",
                      valid_out, idx_out, data_out, ready_in);
    end
    @(posedge clk); #1 valid_in = 1; data_in = 12'h001;
    @(posedge clk); #1 valid_in = 0;
    for (int b = 0; b < PS; b++) begin
      @(negedge clk);
      total++;
      if (valid_out !== 1'b1 || data_out !== 12'h001 || idx_out !== 2'(b)) begin
        bad++; $display("FAIL rstmid_beat%0d: got v=%b d=%h i=%0d want v=1 d=001 i=%0d",
                        b, valid_out, data_out, idx_out, b);
      end
    end
    @(negedge clk);
    total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL rstmid_idle: got %b want 0", valid_out); end
  endtask

  task automatic test_pool1();
    @(posedge clk); #1 valid_in1 = 1; data_in1 = 12'h001; ready_out1 = 1;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
      if (k < 5) data_in1 = 12'(k + 1); else valid_in1 = 0;
      @(negedge clk);
      total++;
      if (valid_out1 !== 1'b1 || last_out1 !== 1'b1 || idx_out1 !== 1'b0 || data_out1 !== 12'(k)) begin
        bad++; $display("FAIL pool1_beat%0d: got v=%b l=%b i=%0d d=%h want v=1 l=1 i=0 d=%h",
                        k, valid_out1, last_out1, idx_out1, data_out1, 12'(k));
      end
    end
    @(negedge clk);
    total++; if (valid_out1 !== 1'b0) begin bad++; $display("FAIL pool1_idle: got %b want 0", valid_out1); end
  endtask

  task automatic test_random();
    int   sent = 0;
    int   cyc  = 0;
    int   in0  = n_in;
    int   out0 = n_out;
    logic pending = 0;
    while (sent < 1000 && cyc < 40000) begin
      @(posedge clk); #1;
      if (!pending) begin
        valid_in = 1'($urandom_range(0, 1));
        data_in  = 12'($urandom_range(0, 4095));
      end
      ready_out = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (valid_in && ready_in) begin sent++; pending = 0; end
      else pending = valid_in;
      cyc++;
    end
    @(posedge clk); #1 valid_in = 0;
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 20000) begin
      ready_out = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
      cyc++;
    end
    ready_out = 1;
    @(negedge clk);
    total++; if (sent != 1000) begin bad++; $display("FAIL rand_sent: got %0d want 1000", sent); end
    total++; if (n_in - in0 != sent) begin bad++; $display("FAIL rand_in_count: got %0d want %0d", n_in - in0, sent); end
    total++; if (n_out - out0 != PS * sent) begin
      bad++; $display("FAIL rand_out_count: got %0d want %0d", n_out - out0, PS * sent);
    end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL rand_leftover: got %0d want 0", exp_q.size()); end
    total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL rand_idle: got %b want 0", valid_out); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_pool1();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gupsample.md
GUPSAMPLE -- requirements
Module: gupsample

Interface
REQ-001 Parameter DATA_WIDTH, default 12, width of input and output samples.
REQ-002 Parameter POOL_SIZE, default 250, number of output beats per input sample; legal range is POOL_SIZE >= 1.
REQ-003 Localparam COUNTER_WIDTH SHALL be clog2(POOL_SIZE) from cnn1d_pkg, minimum 1.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 gupsample_ready_in  output  1  block can accept an input sample this cycle.
REQ-007 gupsample_valid_in  input  1  upstream presents a sample.
REQ-008 gupsample_data_in  input  DATA_WIDTH  sample to broadcast.
REQ-009 gupsample_ready_out  input  1  downstream accepts the current output beat.
REQ-010 gupsample_valid_out  output  1  output beat present.
REQ-011 gupsample_data_out  output  DATA_WIDTH  held sample value.
REQ-012 gupsample_index_out  output  COUNTER_WIDTH  position of the current beat within the pool, 0..POOL_SIZE-1.
REQ-013 gupsample_last_out  output  1  current beat is index POOL_SIZE-1.

Function
REQ-014 The block SHALL act as the inverse of global average pooling: one accepted input sample produces exactly POOL_SIZE output beats, each carrying that sample unchanged.
REQ-015 Two-state FSM: IDLE has valid_out=0 and ready_in=1; BCAST has valid_out=1.
REQ-016 Input handshake = ready_in & valid_in; output handshake = valid_out & ready_out.
REQ-017 An input handshake in IDLE SHALL register data_in, clear the index to 0 and enter BCAST, so the first output beat is valid on the next cycle (latency 1).
REQ-018 In BCAST, an output handshake with index < POOL_SIZE-1 SHALL increment the index by 1.
REQ-019 While ready_out=0 in BCAST, data_out, index_out, last_out and valid_out SHALL hold their values.
REQ-020 last_out = valid_out & (index == POOL_SIZE-1), registered state only.
REQ-021 ready_in in BCAST SHALL be last_out & ready_out (combinational), and 0 otherwise in BCAST.
REQ-022 On the final-beat handshake with a simultaneous input handshake, the block SHALL load the new sample, clear the index to 0 and remain in BCAST, with no bubble cycle.
REQ-023 On the final-beat handshake without an input handshake, the block SHALL return to IDLE and deassert valid_out on the next cycle.
REQ-024 POOL_SIZE=1: every beat SHALL have last_out=1, and back-to-back inputs SHALL sustain one output per cycle.
REQ-025 The index counter SHALL never exceed POOL_SIZE-1, so non-power-of-two POOL_SIZE never wraps through unused codes.
REQ-026 data_out SHALL equal the held register in both states and SHALL only change on an input handshake.

Reset
REQ-027 While rst=1 at a clock edge, the FSM SHALL go to IDLE, and the index and data register SHALL go to 0.
REQ-028 After reset, outputs SHALL be valid_out=0, last_out=0, index_out=0, data_out=0 and ready_in=1.
REQ-029 Reset during BCAST SHALL abandon the remaining beats, with no further output beat for that sample.
REQ-030 Reset SHALL take priority over any simultaneous handshake.

Verification (bench with DATA_WIDTH=12, POOL_SIZE=4)
REQ-031 Single sample 0x123 with ready_out held at 1 -> valid_out rises 1 cycle after acceptance; 4 beats of 0x123 with index 0,1,2,3; last_out only on index 3; then IDLE.
REQ-032 Back-to-back inputs 0x0AA then 0x055, with valid_in held and ready_out=1 -> 8 consecutive beats with no gap; ready_in pulses only on the index-3 cycle; the data changes on beat 5.
REQ-033 Backpressure: ready_out toggles 1,0,0,1,... during a broadcast of 0xFFF -> outputs stable during stalls; exactly 4 handshakes; ready_in stays 0 until the final handshake.
REQ-034 rst asserted after 2 beats of 0x300 -> next cycle valid_out=0, index_out=0, data_out=0, ready_in=1; the subsequent sample 0x001 produces a full 4 beats.
REQ-035 Rebuild with POOL_SIZE=1, streaming 0x001..0x005 with ready_out=1 -> 5 beats on 5 consecutive cycles, each with last_out=1 and index_out=0.
REQ-036 Random valid_in/ready_out scoreboard, 1000 samples -> output count = 4 × input count; each group of 4 equals the corresponding input in order.
